bcd_code_converter_seq: RTL and testbench

Digit-serial, parametrised successor to the single-digit combinational BCD code converter. Accepts a packed word of DIGITS BCD digits over a valid/ready handshake and converts one digit per clock into a run-time selectable 4-bit code: excess-3, 2421 (Aiken), Gray or 84-2-1. Flags non-BCD digits per position. Sits between a BCD source, such as a counter or keypad encoder, and a display or transmit stage that expects the alternate code.

---
 rtl/bcd_conv_pkg.sv | 17 +
 rtl/bcd_digit_map.sv | 44 ++++
 rtl/bcd_code_converter_seq.sv | 102 ++++++++++
 tb/tb_bcd_code_converter_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_conv_pkg.sv
// rtl/bcd_conv_pkg.sv - shared mode codes, FSM encoding and fill value for the BCD converter
package bcd_conv_pkg;

  localparam logic [1:0] MODE_XS3   = 2'd0;
  localparam logic [1:0] MODE_2421  = 2'd1;
  localparam logic [1:0] MODE_GRAY  = 2'd2;
  localparam logic [1:0] MODE_8421N = 2'd3;

  localparam logic [3:0] INVALID_FILL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_digit_map.sv
// rtl/bcd_digit_map.sv - combinational map of one BCD digit into the selected 4-bit code
module bcd_digit_map
  import bcd_conv_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic [1:0] mode_i,
  output logic [3:0] code_o,
  output logic       err_o
);

  logic [3:0] neg_code;

  always_comb begin
    neg_code = 4'h0;
    case (digit_i)
      4'd1:    neg_code = 4'h7;
      4'd2:    neg_code = 4'h6;
      4'd3:    neg_code = 4'h5;
      4'd4:    neg_code = 4'h4;
      4'd5:    neg_code = 4'hB;
      4'd6:    neg_code = 4'hA;
      4'd7:    neg_code = 4'h9;
      4'd8:    neg_code = 4'h8;
      4'd9:    neg_code = 4'hF;
      default: neg_code = 4'h0;
    endcase
  end

  always_comb begin
    code_o = INVALID_FILL;
    err_o  = 1'b0;
    if (digit_i > 4'd9) begin
      err_o = 1'b1;
    end else begin
      case (mode_i)
        MODE_XS3:  code_o = digit_i + 4'd3;
        MODE_2421: code_o = (digit_i <= 4'd4) ? digit_i : digit_i + 4'd6;
        MODE_GRAY: code_o = digit_i ^ (digit_i >> 1);
        default:   code_o = neg_code;
      endcase
    end
  end

endmodule

// File: rtl/bcd_code_converter_seq.sv
// rtl/bcd_code_converter_seq.sv - digit-serial BCD code converter, one digit per clock
module bcd_code_converter_seq
  import bcd_conv_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_code,
  output logic                  out_err,
  output logic [DIGITS-1:0]     err_digit
);

  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  state_e               state_q, state_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]  bcd_q, bcd_d;
  logic [1:0]           mode_q, mode_d;
  logic [4*DIGITS-1:0]  result_q, result_d;
  logic [DIGITS-1:0]    err_q, err_d;

  logic [3:0] cur_digit;
  logic [3:0] cur_code;
  logic       cur_err;

  assign cur_digit = bcd_q[4*int'(idx_q) +: 4];

  bcd_digit_map u_map (
    .digit_i (cur_digit),
    .mode_i  (mode_q),
    .code_o  (cur_code),
    .err_o   (cur_err)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    bcd_d    = bcd_q;
    mode_d   = mode_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          bcd_d    = in_bcd;
          mode_d   = mode;
          result_d = '0;
          err_d    = '0;
          idx_d    = '0;
          state_d  = ST_CONV;
        end
      end
      ST_CONV: begin
        result_d[4*int'(idx_q) +: 4] = cur_code;
        err_d[idx_q]                 = cur_err;
        idx_d                        = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      bcd_q    <= '0;
      mode_q   <= MODE_XS3;
      result_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      bcd_q    <= bcd_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Handshake outputs decode from state alone, so no input-to-output combinational path exists.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_code  = result_q;
  assign err_digit = err_q;
  assign out_err   = |err_q;

endmodule

// File: tb/tb_bcd_code_converter_seq.sv
// tb/tb_bcd_code_converter_seq.sv - directed self-checking bench for bcd_code_converter_seq
module tb_bcd_code_converter_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bcd;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_code;
  logic        out_err;
  logic [3:0]  err_digit;

  logic        in_valid1;
  logic        in_ready1;
  logic [3:0]  in_bcd1;
  logic [1:0]  mode1;
  logic        out_valid1;
  logic        out_ready1;
  logic [3:0]  out_code1;
  logic        out_err1;
  logic [0:0]  err_digit1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_code_converter_seq #(.DIGITS(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_err   (out_err),
    .err_digit (err_digit)
  );

  bcd_code_converter_seq #(.DIGITS(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_bcd    (in_bcd1),
    .mode      (mode1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_code  (out_code1),
    .out_err   (out_err1),
    .err_digit (err_digit1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; returns with DUT in DONE (or timed out), #1 after an edge.
  task automatic run_word(input logic [15:0] bcd, input logic [1:0] m, input bit wiggle,
                          output int lat);
    check("ready_before_accept", 32'(in_ready), 32'd1);
    in_bcd   = bcd;
    mode     = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      if (wiggle) begin
        mode   = 2'($urandom);
        in_bcd = 16'($urandom);
      end
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("ready_after_pop", 32'(in_ready), 32'd1);
    check("valid_after_pop", 32'(out_valid), 32'd0);
  endtask

  int  lat;
  bit  saw_valid;

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_bcd     = 16'h1234;
    mode       = 2'd0;
    out_ready  = 1'b0;
    in_valid1  = 1'b1;
    in_bcd1    = 4'h8;
    mode1      = 2'd2;
    out_ready1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_valid1 = 1'b0;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_code",  32'(out_code),  32'h0);
    check("rst_out_err",   32'(out_err),   32'd0);
    check("rst_err_digit", 32'(err_digit), 32'h0);

    run_word(16'h1234, 2'd0, 1'b0, lat);
    check("xs3_latency", 32'(lat), 32'd4);
    check("xs3_code", 32'(out_code), 32'h4567);
    check("xs3_err",  32'(out_err),  32'd0);
    pop();

    run_word(16'h5979, 2'd1, 1'b0, lat);
    check("2421_code", 32'(out_code), 32'hBFDF);
    pop();

    run_word(16'h0987, 2'd2, 1'b0, lat);
    check("gray_code", 32'(out_code), 32'h0DC4);
    pop();

    run_word(16'h1209, 2'd3, 1'b0, lat);
    check("n8421_code", 32'(out_code),  32'h760F);
    check("n8421_errd", 32'(err_digit), 32'h0);
    pop();

    run_word(16'h12A4, 2'd0, 1'b0, lat);
    check("inv_code", 32'(out_code),  32'h45F7);
    check("inv_errd", 32'(err_digit), 32'b0010);
    check("inv_err",  32'(out_err),   32'd1);
    pop();

    run_word(16'h1234, 2'd2, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_code",  32'(out_code),  32'h1326);
      check("bp_ready", 32'(in_ready),  32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    pop();

    run_word(16'h5979, 2'd1, 1'b1, lat);
    check("latched_mode_lat",  32'(lat),      32'd4);
    check("latched_mode_code", 32'(out_code), 32'hBFDF);
    pop();

    in_bcd   = 16'h1234;
    mode     = 2'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_ready", 32'(in_ready),  32'd1);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_code",  32'(out_code),  32'h0);
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check("midrst_no_valid", 32'(saw_valid), 32'd0);

    run_word(16'h9999, 2'd0, 1'b0, lat);
    check("post_rst_code", 32'(out_code), 32'hCCCC);
    pop();

    check("d1_ready", 32'(in_ready1), 32'd1);
    in_bcd1   = 4'h8;
    mode1     = 2'd2;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (out_valid1) begin
        lat = n;
        break;
      end
    end
    check("d1_latency", 32'(lat), 32'd1);
    check("d1_code",    32'(out_code1), 32'hC);
    check("d1_err",     32'(out_err1),  32'd0);
    out_ready1 = 1'b1;
    @(posedge clk);
    #1;
    out_ready1 = 1'b0;

    in_bcd1   = 4'hB;
    mode1     = 2'd1;
    in_valid1 = 1'b1;
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    @(posedge clk);
    #1;
    check("d1_inv_valid", 32'(out_valid1), 32'd1);
    check("d1_inv_code",  32'(out_code1),  32'hF);
    check("d1_inv_err",   32'(out_err1),   32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
